// File: rtl/list_pkg.sv
// ---------------------------------------------------------------------------
// list_pkg
// Shared definitions for the lazy-list prefetch buffer.
//   LIST_WIDTH     : default element width
//   LIST_END_VALUE : value driven on out_value with an end-of-list ack
//   fetch_state_t  : upstream fetch FSM states
//   sat_inc16      : saturating 16-bit increment used by the optional stats
// ---------------------------------------------------------------------------
package list_pkg;

   localparam int LIST_WIDTH = 8;
   localparam logic [LIST_WIDTH-1:0] LIST_END_VALUE = {LIST_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/list_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// list_prefetch_fifo
// DEPTH x WIDTH ring buffer holding prefetched list elements.
// Ports:
//   clock      in   clock, all updates on posedge
//   ready      in   synchronous active-low reset (clears pointers and level)
//   push       in   write push_data at the tail
//   push_data  in   element to store
//   pop        in   advance the head (caller guarantees level>0)
//   head       out  element at the head, read from the storage registers
//   level      out  number of entries buffered
// The caller never pushes into a full ring, so no overflow guard is needed.
// ---------------------------------------------------------------------------
module list_prefetch_fifo
   import list_pkg::*;
#(
   parameter int WIDTH = LIST_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     ready,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;

   // Element storage; contents need no reset because level gates every read.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clock) begin
      if (!ready) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign level = level_r;

endmodule

// File: rtl/list_prefetch.sv
// ---------------------------------------------------------------------------
// list_prefetch
// Prefetching element buffer between a lazy-list producer and its consumer.
// Both sides use the req/ack/value/value_valid list protocol; elements are
// pulled ahead of demand into a small ring, end-of-list is latched and replayed.
// Ports:
//   clock, ready                 clock and synchronous active-low reset
//   in_req / in_ack / in_value / in_value_valid     upstream side
//   out_req / out_ack / out_value / out_value_valid downstream side
//   level                        entries currently buffered
//   eos                          upstream end of list latched
//   served_count                 (LIST_PREFETCH_STATS_EN only) valid acks served,
//                                saturating at 16'hFFFF
// Build option: define LIST_PREFETCH_STATS_EN to add the served_count output.
// ---------------------------------------------------------------------------
module list_prefetch
   import list_pkg::*;
#(
   parameter int WIDTH = LIST_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     ready,
   output logic                     in_req,
   input  logic                     in_ack,
   input  logic [WIDTH-1:0]         in_value,
   input  logic                     in_value_valid,
   input  logic                     out_req,
   output logic                     out_ack,
   output logic [WIDTH-1:0]         out_value,
   output logic                     out_value_valid,
   output logic [$clog2(DEPTH):0]   level,
`ifdef LIST_PREFETCH_STATS_EN
   output logic [15:0]              served_count,
`endif
   output logic                     eos
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   fetch_state_t     state_r;
   logic             in_req_r;
   logic             eos_r;
   logic             out_ack_r;
   logic [WIDTH-1:0] out_value_r;
   logic             out_value_valid_r;
   logic             pending_r;
   logic             last_out_req_r;

   logic [LW-1:0]    fifo_level_s;
   logic [WIDTH-1:0] head_s;
   logic             push_s;
   logic             pop_s;
   logic             pending_s;
   logic             serve_end_s;

   // Only a valid element accepted while requesting is stored; the end marker sets eos instead.
   assign push_s      = (state_r == REQ) & in_ack & in_value_valid;
   // A fresh request edge is served in the same cycle it is seen, giving 1-cycle latency.
   assign pending_s   = pending_r | (out_req & ~last_out_req_r);
   assign pop_s       = pending_s & (fifo_level_s != {LW{1'b0}});
   assign serve_end_s = pending_s & (fifo_level_s == {LW{1'b0}}) & eos_r;

   list_prefetch_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .ready     (ready),
      .push      (push_s),
      .push_data (in_value),
      .pop       (pop_s),
      .head      (head_s),
      .level     (fifo_level_s)
   );

   // Upstream fetch FSM: one outstanding request, with a forced low cycle between requests.
   always_ff @(posedge clock) begin
      if (!ready) begin
         state_r  <= IDLE;
         in_req_r <= 1'b0;
         eos_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               // Entering REQ only with a free slot reserves room for the reply.
               if (!eos_r && (fifo_level_s < DEPTH_L)) begin
                  state_r  <= REQ;
                  in_req_r <= 1'b1;
               end
            end
            REQ: begin
               if (in_ack) begin
                  in_req_r <= 1'b0;
                  if (in_value_valid) begin
                     state_r <= GAP;
                  end else begin
                     eos_r   <= 1'b1;
                     state_r <= DONE;
                  end
               end
            end
            GAP: begin
               state_r <= IDLE;
            end
            DONE: begin
               in_req_r <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               in_req_r <= 1'b0;
            end
         endcase
      end
   end

   // Downstream serve logic: edge detection, pending request and registered ack/value.
   always_ff @(posedge clock) begin
      if (!ready) begin
         last_out_req_r    <= 1'b0;
         pending_r         <= 1'b0;
         out_ack_r         <= 1'b0;
         out_value_r       <= {WIDTH{1'b1}};
         out_value_valid_r <= 1'b0;
      end else begin
         last_out_req_r <= out_req;
         out_ack_r      <= 1'b0;
         if (pop_s) begin
            out_ack_r         <= 1'b1;
            out_value_r       <= head_s;
            out_value_valid_r <= 1'b1;
            pending_r         <= 1'b0;
         end else if (serve_end_s) begin
            out_ack_r         <= 1'b1;
            out_value_r       <= {WIDTH{1'b1}};
            out_value_valid_r <= 1'b0;
            pending_r         <= 1'b0;
         end else begin
            pending_r <= pending_s;
         end
      end
   end

`ifdef LIST_PREFETCH_STATS_EN
   logic [15:0] served_count_r;

   // Count acks carrying a real element.
   always_ff @(posedge clock) begin
      if (!ready) begin
         served_count_r <= 16'd0;
      end else if (pop_s) begin
         served_count_r <= sat_inc16(served_count_r);
      end else begin
         served_count_r <= served_count_r;
      end
   end

   assign served_count = served_count_r;
`endif

   assign in_req          = in_req_r;
   assign out_ack         = out_ack_r;
   assign out_value       = out_value_r;
   assign out_value_valid = out_value_valid_r;
   assign level           = fifo_level_s;
   assign eos             = eos_r;

endmodule
